// File: rtl/ip_uart_rx_pkg.sv
// ip_uart_rx_pkg
// Shared types and constants for the ip_uart_rx receiver slice:
//   - uart_rx_state_e : de-framer state encoding
//   - FIFO_*          : receive FIFO geometry
//   - majority3()     : 2-of-3 vote used to sample the serial line
package ip_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_rx_state_e;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

endpackage

// File: rtl/ip_uart_rx_if.sv
// ip_uart_rx_if
// Valid/ready byte stream from the UART receiver to its consumer.
//   recv_data  : byte at the FIFO head, meaningful only while recv_valid=1
//   recv_valid : FIFO not empty
//   recv_ready : consumer takes the head byte when recv_valid & recv_ready
// master = receiver (producer), slave = consumer.
interface ip_uart_rx_if;

    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ready;

    modport master (
        output recv_data,
        output recv_valid,
        input  recv_ready
    );

    modport slave (
        input  recv_data,
        input  recv_valid,
        output recv_ready
    );

endinterface

// File: rtl/ip_uart_rx_fifo.sv
// ip_uart_rx_fifo
// 4 x 8 register FIFO for received bytes.
//   clk, n_reset : clock, asynchronous active-low reset
//   push         : write push_data this cycle
//   push_data    : byte to store
//   pop_req      : consumer handshake (ignored while empty)
//   rd_data      : head entry
//   empty        : no entries held
//   overflow     : registered one-cycle pulse when a push is dropped
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle; the freed slot is the one being written.
module ip_uart_rx_fifo import ip_uart_rx_pkg::*; (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_req,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       overflow
);

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full;
    logic                  pop;
    logic                  push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign pop      = pop_req && !empty;
    assign push_ok  = push && (!full || pop);
    assign rd_data  = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push && !push_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/ip_uart_rx.sv
// ip_uart_rx
// 8N1 UART receiver: synchronizes the serial line, samples each bit at its
// centre with a 3-sample majority vote, de-frames bytes and buffers them in
// a 4-entry FIFO presented on a valid/ready stream.
//   clk, n_reset : clock, asynchronous active-low reset
//   uart_rx      : serial line, idle high, asynchronous to clk
//   recv         : ip_uart_rx_if master (recv_data/recv_valid/recv_ready)
//   frame_error  : one-cycle pulse when a stop bit is sampled low
//   overflow     : one-cycle pulse when a good byte is dropped (FIFO full)
module ip_uart_rx import ip_uart_rx_pkg::*; #(
    parameter int unsigned clk_freq  = 14318180,
    parameter int unsigned uart_freq = 115200
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         uart_rx,
    ip_uart_rx_if.master recv,
    output logic         frame_error,
    output logic         overflow
);

    localparam int unsigned BIT_CYCLES = clk_freq / uart_freq;
    localparam int unsigned HALF       = BIT_CYCLES / 2;
    localparam int unsigned CNT_W      = $clog2(BIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_M1  = CNT_W'(BIT_CYCLES - 1);

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic [2:0]     hist_q, hist_d;
    uart_rx_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     data_q, data_d;
    logic           frame_error_q, frame_error_d;

    logic           sample;
    logic           push;
    logic           fifo_empty;

    assign sync1_d = uart_rx;
    assign sync2_d = sync1_q;
    assign hist_d  = {hist_q[1:0], sync2_q};
    assign sample  = majority3(hist_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        data_d        = data_q;
        push          = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    // The detecting cycle is the first start-bit cycle, so the
                    // counter already reads 1 on the following cycle.
                    cnt_d   = CNT_W'(1);
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF_M1) begin
                    if (sample) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_BIT_M1) begin
                    cnt_d     = '0;
                    data_d    = {sample, data_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_BIT_M1) begin
                    cnt_d = '0;
                    if (sample) begin
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                // A held-low line (break) produces a single frame_error.
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            hist_q        <= 3'b111;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            data_q        <= '0;
            frame_error_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            hist_q        <= hist_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            data_q        <= data_d;
            frame_error_q <= frame_error_d;
        end
    end

    ip_uart_rx_fifo u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .push_data (data_q),
        .pop_req   (recv.recv_valid && recv.recv_ready),
        .rd_data   (recv.recv_data),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign recv.recv_valid = !fifo_empty;
    assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_ip_uart_rx.sv
// tb_ip_uart_rx
// Directed + randomized bench for ip_uart_rx at the default 124 clk/bit.
// Bytes are serialized by a task; a monitor logs every accepted byte, every
// frame_error/overflow cycle and recv_valid rises. A queue-based model of a
// 4-deep buffer predicts which bytes come out and how many are dropped.
module tb_ip_uart_rx;
    import ip_uart_rx_pkg::*;

    localparam int unsigned BITC = 124;

    logic clk = 1'b0;
    logic n_reset;
    logic uart_rx;
    logic frame_error;
    logic overflow;

    ip_uart_rx_if rx_if ();

    ip_uart_rx #(
        .clk_freq  (14318180),
        .uart_freq (115200)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .uart_rx     (uart_rx),
        .recv        (rx_if),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned fe_cnt = 0;
    int unsigned ovf_cnt = 0;
    int unsigned valid_cycles = 0;
    int unsigned rise_cyc = 0;
    int unsigned fe_cyc = 0;
    int unsigned ovf_cyc = 0;
    int unsigned last_start = 0;
    int unsigned exp_fe = 0;
    int unsigned exp_ovf = 0;
    logic        prev_valid = 1'b0;

    logic [7:0]  got[$];
    int unsigned got_cyc[$];
    logic [7:0]  mq[$];
    logic [7:0]  exp_pop[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_reset) begin
            if (rx_if.recv_valid && rx_if.recv_ready) begin
                got.push_back(rx_if.recv_data);
                got_cyc.push_back(cyc);
            end
            if (frame_error) begin
                fe_cnt <= fe_cnt + 1;
                fe_cyc <= cyc;
            end
            if (overflow) begin
                ovf_cnt <= ovf_cnt + 1;
                ovf_cyc <= cyc;
            end
            if (rx_if.recv_valid && !prev_valid) rise_cyc <= cyc;
            if (rx_if.recv_valid) valid_cycles <= valid_cycles + 1;
        end
        prev_valid <= rx_if.recv_valid;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference buffer: a good byte is kept if there is room or the consumer
    // takes the head in the same cycle; otherwise it is counted as dropped.
    task automatic m_good(input logic [7:0] b, input bit pop_now);
        if (mq.size() < 4 || pop_now) begin
            if (pop_now && mq.size() > 0) exp_pop.push_back(mq.pop_front());
            mq.push_back(b);
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic m_drain();
        while (mq.size() > 0) exp_pop.push_back(mq.pop_front());
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_pop.size()));
        for (int i = 0; i < got.size() && i < exp_pop.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_pop[i]));
    endtask

    task automatic sb_clear();
        got.delete();
        got_cyc.delete();
        exp_pop.delete();
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic tx_bit(input logic v, input int unsigned len);
        uart_rx = v;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int unsigned stop_len);
        last_start = cyc;
        tx_bit(1'b0, BITC);
        for (int i = 0; i < 8; i++) tx_bit(b[i], BITC);
        tx_bit(stop_v, stop_len);
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int unsigned s;
        int unsigned vc0;
        int unsigned fe0;
        int unsigned n;
        logic [7:0]  b;
        logic [7:0]  partial;

        n_reset = 1'b0;
        uart_rx = 1'b1;
        rx_if.recv_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rx_if.recv_valid), 0);
        chk("rst_data",  32'(rx_if.recv_data), 0);
        chk("rst_fe",    32'(frame_error), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tx_bit(1'b1, 20);

        // Single byte, consumer always ready.
        rx_if.recv_ready = 1'b1;
        vc0 = valid_cycles;
        send_byte(8'h41, 1'b1, BITC);
        m_good(8'h41, 1'b0);
        m_drain();
        tx_bit(1'b1, 20);
        chk("b41_rise_cycle", rise_cyc, last_start + 1180);
        chk("b41_valid_len", valid_cycles - vc0, 1);
        chk("b41_fe", fe_cnt, exp_fe);
        sb_check("b41");
        sb_clear();

        // 20-cycle glitch on an idle line.
        vc0 = valid_cycles;
        s = cyc;
        tx_bit(1'b0, 20);
        uart_rx = 1'b1;
        wait_cyc(s + 63);
        chk("glitch_in_start", 32'(dut.state_q), 32'(ST_START));
        wait_cyc(s + 64);
        chk("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        tx_bit(1'b1, 200);
        chk("glitch_valid", valid_cycles - vc0, 0);
        chk("glitch_fe", fe_cnt, exp_fe);

        // Stop bit held low (break) then a good frame.
        vc0 = valid_cycles;
        send_byte(8'h55, 1'b0, 300);
        exp_fe++;
        tx_bit(1'b1, 200);
        chk("brk_fe_count", fe_cnt, exp_fe);
        chk("brk_fe_cycle", fe_cyc, last_start + 1180);
        chk("brk_no_push", valid_cycles - vc0, 0);
        send_byte(8'hAA, 1'b1, BITC);
        m_good(8'hAA, 1'b0);
        m_drain();
        tx_bit(1'b1, 20);
        sb_check("after_brk");
        sb_clear();

        // Overflow: five back-to-back bytes with nobody reading.
        rx_if.recv_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, BITC);
            m_good(8'(i), 1'b0);
        end
        tx_bit(1'b1, 20);
        chk("ovf_count", ovf_cnt, exp_ovf);
        chk("ovf_cycle", ovf_cyc, last_start + 1180);
        chk("ovf_valid_held", 32'(rx_if.recv_valid), 1);
        rx_if.recv_ready = 1'b1;
        m_drain();
        tx_bit(1'b1, 10);
        rx_if.recv_ready = 1'b0;
        sb_check("ovf_drain");
        for (int i = 1; i < got_cyc.size(); i++)
            chk($sformatf("ovf_drain_gap%0d", i), got_cyc[i] - got_cyc[i-1], 1);
        sb_clear();

        // Full FIFO, pop in the same cycle as the fifth push.
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, BITC);
            m_good(8'(i), 1'b0);
        end
        fork
            send_byte(8'h05, 1'b1, BITC);
            begin
                repeat (1179) @(posedge clk);
                #1;
                rx_if.recv_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_if.recv_ready = 1'b0;
            end
        join
        m_good(8'h05, 1'b1);
        tx_bit(1'b1, 20);
        chk("samecyc_ovf", ovf_cnt, exp_ovf);
        chk("samecyc_pop_cycle", got_cyc.size() > 0 ? got_cyc[0] : 0, last_start + 1179);
        rx_if.recv_ready = 1'b1;
        m_drain();
        tx_bit(1'b1, 10);
        sb_check("samecyc");
        sb_clear();

        // Reset in the middle of bit 4 with one byte still buffered.
        rx_if.recv_ready = 1'b0;
        send_byte(8'h3C, 1'b1, BITC);
        m_good(8'h3C, 1'b0);
        tx_bit(1'b1, 10);
        chk("rstmid_pre_valid", 32'(rx_if.recv_valid), 1);
        partial = 8'h96;
        tx_bit(1'b0, BITC);
        for (int i = 0; i < 4; i++) tx_bit(partial[i], BITC);
        uart_rx = partial[4];
        repeat (60) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #2;
        chk("rstmid_valid", 32'(rx_if.recv_valid), 0);
        chk("rstmid_data",  32'(rx_if.recv_data), 0);
        chk("rstmid_fe",    32'(frame_error), 0);
        chk("rstmid_ovf",   32'(overflow), 0);
        mq.delete();
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_reset = 1'b1;
        tx_bit(1'b1, 20);
        chk("rstmid_after_valid", 32'(rx_if.recv_valid), 0);
        chk("rstmid_after_state", 32'(dut.state_q), 32'(ST_IDLE));
        rx_if.recv_ready = 1'b1;
        send_byte(8'hC3, 1'b1, BITC);
        m_good(8'hC3, 1'b0);
        m_drain();
        tx_bit(1'b1, 20);
        sb_check("rstmid_c3");
        sb_clear();

        // Randomized bursts with the consumer stalled, then drained.
        fe0 = fe_cnt;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            rx_if.recv_ready = 1'b0;
            for (int k = 0; k < int'(n); k++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1, BITC);
                m_good(b, 1'b0);
            end
            tx_bit(1'b1, 20);
            chk($sformatf("rnd%0d_ovf", r), ovf_cnt, exp_ovf);
            rx_if.recv_ready = 1'b1;
            m_drain();
            tx_bit(1'b1, 20);
            sb_check($sformatf("rnd%0d", r));
            sb_clear();
        end

        // Randomized bytes with the consumer always ready.
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, BITC);
            m_good(b, 1'b0);
            m_drain();
        end
        tx_bit(1'b1, 20);
        sb_check("rnd_ready");
        sb_clear();
        chk("rnd_fe", fe_cnt - fe0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
